// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter: three one-entry request buffers feeding a single registered GPR write port.
// Define GPR_WB_RR_EN for round-robin arbitration; otherwise fixed priority with starvation promotion.
module gpr_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              csr_valid,
    input  logic [4:0]        csr_rd,
    input  logic [DATA_W-1:0] csr_data,
    output logic              csr_ready,
    input  logic              fpu_valid,
    input  logic [4:0]        fpu_rd,
    input  logic [DATA_W-1:0] fpu_data,
    output logic              fpu_ready,
    output logic              wen,
    output logic [4:0]        waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        wsrc,
    output logic [31:0]       pending,
    output logic              idle
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_CSR = 2'd1;
    localparam logic [1:0] SRC_FPU = 2'd2;

    // Per-source vectors are indexed by source id so the buffers can be handled in loops.
    logic [2:0]        in_valid;
    logic [4:0]        in_rd   [3];
    logic [DATA_W-1:0] in_data [3];

    logic [2:0]        buf_v;
    logic [4:0]        buf_rd   [3];
    logic [DATA_W-1:0] buf_data [3];

    logic [2:0]        gnt_vec;
    logic              gnt_any;
    logic [1:0]        gnt_id;
    logic [4:0]        gnt_rd;
    logic [DATA_W-1:0] gnt_data;
    logic [2:0]        ready_vec;
    logic [2:0]        accept;

    always_comb begin
        in_valid   = {fpu_valid, csr_valid, alu_valid};
        in_rd[0]   = alu_rd;
        in_rd[1]   = csr_rd;
        in_rd[2]   = fpu_rd;
        in_data[0] = alu_data;
        in_data[1] = csr_data;
        in_data[2] = fpu_data;
    end

    // A granted entry leaves on this edge, so its slot may be refilled in the same cycle.
    assign ready_vec = {3{~rst}} & (~buf_v | gnt_vec);
    assign accept    = in_valid & ready_vec;
    assign alu_ready = ready_vec[0];
    assign csr_ready = ready_vec[1];
    assign fpu_ready = ready_vec[2];
    assign gnt_any   = |gnt_vec;

`ifndef GPR_WB_RR_EN
    localparam int                AGE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age [3];
    logic [2:0]       starved;
    logic [2:0]       cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_vec = '0;
        gnt_id  = SRC_ALU;
        for (int i = 0; i < 3; i++) begin
            starved[i] = buf_v[i] && (age[i] == AGE_MAX);
        end
        cand = (|starved) ? starved : buf_v;
        if (cand[SRC_CSR]) begin
            gnt_vec[SRC_CSR] = 1'b1;
            gnt_id           = SRC_CSR;
        end else if (cand[SRC_FPU]) begin
            gnt_vec[SRC_FPU] = 1'b1;
            gnt_id           = SRC_FPU;
        end else if (cand[SRC_ALU]) begin
            gnt_vec[SRC_ALU] = 1'b1;
            gnt_id           = SRC_ALU;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!buf_v[i] || gnt_vec[i]) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] rr_p1;
    logic [1:0] rr_p2;

    // Rotation order CSR -> FPU -> ALU -> CSR.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        case (s)
            SRC_CSR: next_src = SRC_FPU;
            SRC_FPU: next_src = SRC_ALU;
            default: next_src = SRC_CSR;
        endcase
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_vec = '0;
        gnt_id  = SRC_ALU;
        rr_p1   = next_src(rr_ptr);
        rr_p2   = next_src(rr_p1);
        if (buf_v[rr_ptr]) begin
            gnt_id = rr_ptr;
        end else if (buf_v[rr_p1]) begin
            gnt_id = rr_p1;
        end else begin
            gnt_id = rr_p2;
        end
        gnt_vec[gnt_id] = buf_v[gnt_id];
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SRC_CSR;
        end else if (gnt_any) begin
            rr_ptr <= next_src(gnt_id);
        end
    end
`endif

    always_comb begin
        gnt_rd   = '0;
        gnt_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_vec[i]) begin
                gnt_rd   = buf_rd[i];
                gnt_data = buf_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v <= '0;
        end else begin
            buf_v <= (buf_v & ~gnt_vec) | accept;
        end
    end

    // NOTE: payload storage is not reset; buf_v alone qualifies it, and leaving it unreset keeps the data path free of reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
                buf_rd[i]   <= in_rd[i];
                buf_data[i] <= in_data[i];
            end
        end
    end

    // An rd=0 grant still consumes the entry and updates waddr/wdata, but never asserts wen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            wsrc  <= SRC_ALU;
        end else if (gnt_any) begin
            wen   <= (gnt_rd != 5'd0);
            waddr <= gnt_rd;
            wdata <= gnt_data;
            wsrc  <= gnt_id;
        end else begin
            wen <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < 3; i++) begin
            if (buf_v[i]) begin
                pending[buf_rd[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    assign idle = ~|buf_v;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: a per-cycle vector table plus hand-written starvation,
// mid-operation reset and (with GPR_WB_RR_EN) round-robin sequences.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, csr_valid, fpu_valid;
    logic [4:0]  alu_rd, csr_rd, fpu_rd;
    logic [31:0] alu_data, csr_data, fpu_data;
    logic        alu_ready, csr_ready, fpu_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  wsrc;
    logic [31:0] pending;
    logic        idle;

    int n_vec  = 0;
    int n_fail = 0;

    gpr_wb_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .csr_valid(csr_valid), .csr_rd(csr_rd), .csr_data(csr_data), .csr_ready(csr_ready),
        .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wsrc(wsrc),
        .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    // Inputs applied before an edge; expected outputs are those seen just after it.
    typedef struct {
        logic        rst;
        logic [2:0]  v;           // {fpu, csr, alu}
        logic [4:0]  ra, rc, rf;
        logic [31:0] da, dc, df;
        logic        ewen;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic [1:0]  esrc;
        logic [31:0] epend;
        logic        eidle;
        logic [2:0]  erdy;        // {fpu, csr, alu}
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mkv(input logic r, input logic [2:0] v,
                                 input logic [4:0] ra, input logic [4:0] rc, input logic [4:0] rf,
                                 input logic [31:0] da, input logic [31:0] dc, input logic [31:0] df,
                                 input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                                 input logic [1:0] es, input logic [31:0] ep, input logic ei,
                                 input logic [2:0] er);
        vec_t t;
        t.rst = r;   t.v = v;
        t.ra = ra;   t.rc = rc;   t.rf = rf;
        t.da = da;   t.dc = dc;   t.df = df;
        t.ewen = ew; t.eaddr = ea; t.edata = ed; t.esrc = es;
        t.epend = ep; t.eidle = ei; t.erdy = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] ra, input logic [4:0] rc,
                         input logic [4:0] rf, input logic [31:0] da, input logic [31:0] dc,
                         input logic [31:0] df);
        alu_valid = v[0]; csr_valid = v[1]; fpu_valid = v[2];
        alu_rd = ra;   csr_rd = rc;   fpu_rd = rf;
        alu_data = da; csr_data = dc; fpu_data = df;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            done = idle;
        end
        check({name, " drain idle"}, {31'd0, idle}, 32'd1);
        check({name, " drain pending"}, pending, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_src [6];

        rst = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        //                r  v       ra     rc     rf     da            dc        df        wen addr   data          src   pending        idle rdy
        vecs[0]  = mkv(1, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd0,  32'h0,        2'd0, 32'h0,        1, 3'b000);
        vecs[1]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd0,  32'h0,        2'd0, 32'h0,        1, 3'b111);
        vecs[2]  = mkv(0, 3'b001, 5'd5,  5'd0, 5'd0, 32'hDEADBEEF, 32'h0,    32'h0,    0, 5'd0,  32'h0,        2'd0, 32'h20,       0, 3'b111);
        vecs[3]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    1, 5'd5,  32'hDEADBEEF, 2'd0, 32'h0,        1, 3'b111);
        vecs[4]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd5,  32'hDEADBEEF, 2'd0, 32'h0,        1, 3'b111);
        vecs[5]  = mkv(0, 3'b111, 5'd1,  5'd2, 5'd3, 32'h11,       32'h22,   32'h33,   0, 5'd5,  32'hDEADBEEF, 2'd0, 32'hE,        0, 3'b010);
        vecs[6]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    1, 5'd2,  32'h22,       2'd1, 32'hA,        0, 3'b110);
        vecs[7]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    1, 5'd3,  32'h33,       2'd2, 32'h2,        0, 3'b111);
        vecs[8]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    1, 5'd1,  32'h11,       2'd0, 32'h0,        1, 3'b111);
        vecs[9]  = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd1,  32'h11,       2'd0, 32'h0,        1, 3'b111);
        vecs[10] = mkv(0, 3'b100, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h1234, 0, 5'd1,  32'h11,       2'd0, 32'h0,        0, 3'b111);
        vecs[11] = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd0,  32'h1234,     2'd2, 32'h0,        1, 3'b111);
        vecs[12] = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd0,  32'h1234,     2'd2, 32'h0,        1, 3'b111);
        vecs[13] = mkv(0, 3'b001, 5'd9,  5'd0, 5'd0, 32'hA,        32'h0,    32'h0,    0, 5'd0,  32'h1234,     2'd2, 32'h200,      0, 3'b111);
        vecs[14] = mkv(0, 3'b001, 5'd10, 5'd0, 5'd0, 32'hB,        32'h0,    32'h0,    1, 5'd9,  32'hA,        2'd0, 32'h400,      0, 3'b111);
        vecs[15] = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    1, 5'd10, 32'hB,        2'd0, 32'h0,        1, 3'b111);
        vecs[16] = mkv(0, 3'b000, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,    0, 5'd10, 32'hB,        2'd0, 32'h0,        1, 3'b111);

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].v, vecs[i].ra, vecs[i].rc, vecs[i].rf, vecs[i].da, vecs[i].dc, vecs[i].df);
            tick();
            check($sformatf("v%0d wen", i),     {31'd0, wen},   {31'd0, vecs[i].ewen});
            check($sformatf("v%0d waddr", i),   {27'd0, waddr}, {27'd0, vecs[i].eaddr});
            check($sformatf("v%0d wdata", i),   wdata,          vecs[i].edata);
            check($sformatf("v%0d wsrc", i),    {30'd0, wsrc},  {30'd0, vecs[i].esrc});
            check($sformatf("v%0d pending", i), pending,        vecs[i].epend);
            check($sformatf("v%0d idle", i),    {31'd0, idle},  {31'd0, vecs[i].eidle});
            check($sformatf("v%0d ready", i),   {29'd0, fpu_ready, csr_ready, alu_ready},
                  {29'd0, vecs[i].erdy});
        end

`ifndef GPR_WB_RR_EN
        // CSR/FPU stream from cycle 0, ALU lands in cycle 1: FPU starves first (granted cycle 4),
        // ALU reaches the limit in cycle 5 and is the only starved entry.
        exp_src = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        drive(3'b110, 5'd0, 5'd2, 5'd3, 32'h0, 32'hC0, 32'hF0);
        tick();
        drive(3'b111, 5'd7, 5'd2, 5'd3, 32'h7777, 32'hC0, 32'hF0);
        tick();
        check("starve alu_ready", {31'd0, alu_ready}, 32'd0);
        check("starve pending7", {31'd0, pending[7]}, 32'd1);
        alu_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            check($sformatf("starve c%0d wen", k),  {31'd0, wen},  32'd1);
            check($sformatf("starve c%0d wsrc", k), {30'd0, wsrc}, {30'd0, exp_src[k-1]});
        end
        check("starve alu waddr", {27'd0, waddr}, 32'd7);
        check("starve alu wdata", wdata, 32'h7777);
        drain("starve");
`endif

        // Reset with every buffer full discards all three entries.
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        tick();
        check("rstmid full", {31'd0, idle}, 32'd0);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        tick();
        check("rstmid pending", pending, 32'd0);
        check("rstmid idle", {31'd0, idle}, 32'd1);
        check("rstmid wen", {31'd0, wen}, 32'd0);
        check("rstmid waddr", {27'd0, waddr}, 32'd0);
        check("rstmid ready in rst", {29'd0, fpu_ready, csr_ready, alu_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rstmid ready after", {29'd0, fpu_ready, csr_ready, alu_ready}, 32'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstmid no wen %0d", k), {31'd0, wen}, 32'd0);
        end

`ifdef GPR_WB_RR_EN
        // Pointer was reset to CSR above; saturated inputs rotate CSR, FPU, ALU.
        exp_src = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr c%0d wen", k),  {31'd0, wen},  32'd1);
            check($sformatf("rr c%0d wsrc", k), {30'd0, wsrc}, {30'd0, exp_src[k]});
        end
        drain("rr");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Writeback arbiter for the integer register file write port. Three producers (integer/immediate ALU path, CSR read-back, FPU integer result) each hand over a one-entry writeback request. The block buffers the requests, grants one per cycle and drives a single registered write port into the GPR file. It also exports a scoreboard of destination registers with writes still in flight.

## Interface
Parameters:
- `DATA_W`, default 32: writeback data width.
- `STARVE_LIMIT`, default 4: waiting cycles after which a buffered request is promoted to top priority. Legal range 1..15.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `alu_valid`, `csr_valid`, `fpu_valid`  in  1 each: request valid.
- `alu_rd`, `csr_rd`, `fpu_rd`  in  5 each: destination register.
- `alu_data`, `csr_data`, `fpu_data`  in  DATA_W each: writeback data.
- `alu_ready`, `csr_ready`, `fpu_ready`  out  1 each: buffer can accept.
- `wen`  out  1: GPR write enable (registered).
- `waddr`  out  5: GPR write address (registered).
- `wdata`  out  DATA_W: GPR write data (registered).
- `wsrc`  out  2: source of the current write (registered); 0=ALU, 1=CSR, 2=FPU, 3 unused.
- `pending`  out  32: bit r set while any buffer holds a request with rd=r; bit 0 is always 0.
- `idle`  out  1: all buffers empty.

## Operation
- Per-source one-entry buffer: `buf_v`, `buf_rd`, `buf_data`, plus age counter `age` (width ceil(log2(STARVE_LIMIT+1))).
- `x_ready = ~rst & (~buf_v | gnt_x)`. A request is accepted on a clock edge when `x_valid & x_ready`. Accept and grant on the same edge replaces the entry; that source sees no bubble.
- Arbitration is combinational over buffered entries; exactly one grant per cycle when any `buf_v` is set.
  - Starved set: entries with `age == STARVE_LIMIT`. If the starved set is non-empty, grant within it, otherwise among all valid entries.
  - Base priority: CSR > FPU > ALU.
- Age: increments on a cycle where the entry is valid and not granted, saturating at STARVE_LIMIT. Clears on grant or when the buffer is empty.
- Granted entry is registered into the outputs: `waddr<=buf_rd`, `wdata<=buf_data`, `wsrc<=id`, `wen<=(buf_rd!=0)`.
  - An rd=0 grant consumes the entry but produces no write. `waddr`/`wdata` still update; `wen`=0.
- With no grant: `wen<=0`; `waddr`, `wdata`, `wsrc` hold.
- `pending` is the OR of one-hot(buf_rd) over valid buffers, with bit 0 masked. `idle = ~|buf_v`.
- Ordering between sources targeting the same rd is not guaranteed. Issuers must stall while `pending[rd]` is set. The block never drops or merges entries.

## Timing
- Reset (rst high at an edge): all `buf_v`=0, ages 0, `wen`=0, `waddr`=0, `wdata`=0, `wsrc`=0. Round-robin pointer (if compiled) points to CSR. `pending`=0, `idle`=1. Ready outputs are 0 while rst is high.
- Reset mid-operation discards all buffered entries. No write is issued for them.
- Latency: request accepted at edge N → grant in cycle N+1 (if it wins) → `wen` high in cycle N+2, for exactly one cycle per grant.
- Throughput: one write per cycle total. A continuously-winning source sustains 1 request/cycle.
- Worst-case wait for a buffered entry (fixed priority): STARVE_LIMIT cycles plus at most 2 cycles for other starved entries.
- `pending[r]` rises the cycle after acceptance. It falls in the same cycle `wen` rises for that write, since the entry leaves the buffer on the grant edge.

## Configuration
- `GPR_WB_RR_EN` defined:
  - Round-robin arbitration. A 2-bit pointer, reset to CSR, gives priority to the source after the last grantee, in order CSR→FPU→ALU→CSR.
  - Age counters and starvation promotion are compiled out.
- Undefined: fixed priority with starvation promotion as above.

## Test plan
- Single write: `alu_valid` with rd=5, data 0xDEADBEEF, one cycle → `wen`=1 two cycles later, `waddr`=5, `wdata`=0xDEADBEEF, `wsrc`=0. `pending[5]` high for exactly one cycle.
- Simultaneous: all three valid in one cycle, rd ALU=1, CSR=2, FPU=3 → `wen` on three consecutive cycles, waddr 2, 3, 1. `idle` returns to 1 afterwards.
- rd=0: `fpu_valid` with rd=0, data 0x1234 → no `wen`. `fpu_ready` back high; `pending` stays 0.
- Starvation (macro off, STARVE_LIMIT=4): CSR and FPU valid every cycle with rd 2/3, ALU with rd=7 accepted into cycle 1 → cycles 1–4 grant CSR/FPU, ALU granted in cycle 5, `wen` with `waddr`=7 in cycle 6.
- Reset mid-operation: all three buffers full, `rst` high for one edge → no `wen` afterwards, `pending`=0, `idle`=1, ready outputs 1 after `rst` falls.
- `GPR_WB_RR_EN`: all three sources valid every cycle → `wsrc` sequence 1, 2, 0, 1, 2, 0…, one write per cycle.
